mac_pipe: RTL and testbench

Pipelined, parameterised multiply-accumulate unit for the PE ALU; the registered successor to the combinational `mac`. It accepts one operand beat per cycle and supports four modes: single-shot multiply-add, multi-beat accumulation, multiply, and add. It adds guard bits and signed saturation with a sticky overflow flag. Results appear two cycles after the closing beat, qualified by `out_valid`/`done`, so the PE issue logic can stream operands back-to-back.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_sat.sv | 24 ++
 rtl/mac_pipe.sv | 144 ++++++++++++++
 tb/tb_mac_pipe.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared encodings for the pipelined multiply-accumulate unit.
package mac_pkg;

    typedef enum logic [1:0] {
        MODE_MUL_ADD = 2'd0,
        MODE_ACC     = 2'd1,
        MODE_MUL     = 2'd2,
        MODE_ADD     = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/mac_sat.sv
// Combinational signed saturator: clamps a wide two's-complement value into OUT_W bits.
module mac_sat #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic signed [OUT_W-1:0] o_sat,
    output logic                    o_ovf
);

    logic [IN_W-OUT_W:0] w_top;

    assign w_top = i_val[IN_W-1:OUT_W-1];

    // In range only when every bit above the output sign bit copies it.
    always_comb begin
        o_ovf = !((&w_top) || !(|w_top));
        o_sat = i_val[OUT_W-1:0];
        if (o_ovf) begin
            o_sat = i_val[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mac_pipe.sv
// Two-stage pipelined multiply-accumulate with guard bits, saturation and sticky overflow.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int LEN   = 8,
    parameter int GUARD = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic [1:0]              mode,
    input  logic                    in_last,
    input  logic signed [LEN-1:0]   in1,
    input  logic signed [LEN-1:0]   in2,
    input  logic signed [LEN-1:0]   preResult,
    output logic signed [2*LEN-1:0] out,
    output logic signed [2*LEN+GUARD-1:0] out_wide,
    output logic                    overflow,
    output logic                    out_valid,
    output logic                    done
);

    localparam int ACC_LEN = 2*LEN + GUARD;
    localparam int OUT_LEN = 2*LEN;

    logic signed [ACC_LEN-1:0] w_in1_x, w_in2_x, w_pre_x;
    logic signed [ACC_LEN-1:0] r_prod_p1, r_pre_p1;
    mode_e                     r_mode_p1;
    logic                      r_last_p1, r_vld_p1;

    state_e                    r_state, w_state_nxt;
    logic signed [ACC_LEN-1:0] r_acc, w_acc_nxt, w_sum, w_res;
    logic                      r_sticky, w_sticky_nxt;
    logic                      w_emit, w_ovf_emit;
    logic signed [OUT_LEN-1:0] w_sat;
    logic                      w_sat_ovf;

    assign w_in1_x = ACC_LEN'(in1);
    assign w_in2_x = ACC_LEN'(in2);
    assign w_pre_x = ACC_LEN'(preResult);

    // Stage 1: product (or in1 pass-through for ADD) and operand capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_mode_p1 <= MODE_MUL_ADD;
        end else if (en) begin
            r_vld_p1  <= in_valid;
            r_last_p1 <= in_last;
            r_mode_p1 <= mode_e'(mode);
            r_pre_p1  <= w_pre_x;
            r_prod_p1 <= (mode_e'(mode) == MODE_ADD) ? w_in1_x : w_in1_x * w_in2_x;
        end
    end

    // Stage 2: result select; once in ACCUM every beat accumulates whatever its mode
    always_comb begin
        w_sum = r_acc + r_prod_p1;
        w_res = r_prod_p1;
        if (r_state == ST_ACCUM) begin
            w_res = w_sum;
        end else begin
            case (r_mode_p1)
                MODE_MUL_ADD, MODE_ADD: w_res = r_prod_p1 + r_pre_p1;
                default:                w_res = r_prod_p1;
            endcase
        end
    end

    mac_sat #(.IN_W(ACC_LEN), .OUT_W(OUT_LEN)) u_sat (
        .i_val (w_res),
        .o_sat (w_sat),
        .o_ovf (w_sat_ovf)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_sticky_nxt = r_sticky;
        w_emit       = 1'b0;
        w_ovf_emit   = w_sat_ovf;
        if (r_vld_p1) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_mode_p1 == MODE_ACC) begin
                        w_sticky_nxt = w_sat_ovf;
                        if (r_last_p1) begin
                            w_emit = 1'b1;
                        end else begin
                            w_acc_nxt   = w_res;
                            w_state_nxt = ST_ACCUM;
                        end
                    end else begin
                        w_emit = 1'b1;
                    end
                end
                ST_ACCUM: begin
                    w_sticky_nxt = r_sticky | w_sat_ovf;
                    w_ovf_emit   = w_sticky_nxt;
                    if (r_last_p1) begin
                        w_emit      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_acc_nxt = w_res;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else if (en) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            r_sticky  <= 1'b0;
            out       <= '0;
            out_wide  <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            r_acc     <= w_acc_nxt;
            r_sticky  <= w_sticky_nxt;
            out_valid <= w_emit;
            if (w_emit) begin
                out      <= w_sat;
                out_wide <= w_res;
                overflow <= w_ovf_emit;
            end
        end
    end

    assign done = out_valid;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed-vector bench for mac_pipe (LEN=8, GUARD=4); checks sampled on the falling edge.
module tb_mac_pipe;

    logic               clk = 1'b0;
    logic               reset, en, in_valid, in_last;
    logic [1:0]         mode;
    logic signed [7:0]  in1, in2, preResult;
    logic signed [15:0] out;
    logic signed [19:0] out_wide;
    logic               overflow, out_valid, done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_pipe #(.LEN(8), .GUARD(4)) dut (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .mode(mode),
        .in_last(in_last), .in1(in1), .in2(in2), .preResult(preResult),
        .out(out), .out_wide(out_wide), .overflow(overflow),
        .out_valid(out_valid), .done(done)
    );

    task automatic beat(input logic [1:0] m, input int a, input int b, input int p, input logic l);
        in_valid = 1'b1; mode = m; in1 = 8'(a); in2 = 8'(b); preResult = 8'(p); in_last = l;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_last = 1'b0; in1 = '0; in2 = '0; preResult = '0; mode = 2'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; idle();
        repeat (3) @(negedge clk);
        n_vec++; if (out !== 16'sd0) begin n_err++; $display("FAIL reset_out: got %h want 0000", out); end
        n_vec++; if (out_wide !== 20'sd0) begin n_err++; $display("FAIL reset_wide: got %h want 00000", out_wide); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul_add();
        beat(2'd0, -3, 5, 7, 1'b0);
        @(negedge clk); idle();
        @(negedge clk);
        n_vec++; if (out !== 16'hFFF8) begin n_err++; $display("FAIL muladd_out: got %h want fff8", out); end
        n_vec++; if (out_wide !== -20'sd8) begin n_err++; $display("FAIL muladd_wide: got %0d want -8", out_wide); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL muladd_ovf: got %b want 0", overflow); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL muladd_valid: got %b want 1", out_valid); end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL muladd_done: got %b want 1", done); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL muladd_valid_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_acc_pos();
        beat(2'd1, 127, 127, 0, 1'b0);
        @(negedge clk); beat(2'd1, 127, 127, 0, 1'b0);
        @(negedge clk); beat(2'd1, 127, 127, 0, 1'b0);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL accp_mid1: got %b want 0", out_valid); end
        @(negedge clk); beat(2'd1, 127, 127, 0, 1'b1);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL accp_mid2: got %b want 0", out_valid); end
        @(negedge clk); idle();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL accp_mid3: got %b want 0", out_valid); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL accp_valid: got %b want 1", out_valid); end
        n_vec++; if (out_wide !== 20'sd64516) begin n_err++; $display("FAIL accp_wide: got %0d want 64516", out_wide); end
        n_vec++; if (out !== 16'h7FFF) begin n_err++; $display("FAIL accp_out: got %h want 7fff", out); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL accp_ovf: got %b want 1", overflow); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL accp_after_valid: got %b want 0", out_valid); end
        n_vec++; if (out !== 16'h7FFF) begin n_err++; $display("FAIL accp_hold_out: got %h want 7fff", out); end
    endtask

    task automatic test_acc_neg();
        beat(2'd1, -128, 127, 0, 1'b0);
        @(negedge clk); beat(2'd1, -128, 127, 0, 1'b0);
        @(negedge clk); beat(2'd1, -128, 127, 0, 1'b1);
        @(negedge clk); beat(2'd0, 2, 2, 0, 1'b0);
        @(negedge clk); idle();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL accn_valid: got %b want 1", out_valid); end
        n_vec++; if (out_wide !== -20'sd48768) begin n_err++; $display("FAIL accn_wide: got %0d want -48768", out_wide); end
        n_vec++; if (out !== 16'h8000) begin n_err++; $display("FAIL accn_out: got %h want 8000", out); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL accn_ovf: got %b want 1", overflow); end
        @(negedge clk);
        n_vec++; if (out !== 16'sd4) begin n_err++; $display("FAIL accn_next_out: got %0d want 4", out); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL accn_next_ovf: got %b want 0", overflow); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL accn_next_valid: got %b want 1", out_valid); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        beat(2'd2, 1, 1, 0, 1'b0);
        @(negedge clk); beat(2'd2, 2, 2, 0, 1'b0);
        @(negedge clk); beat(2'd2, 3, 3, 0, 1'b0);
        n_vec++; if (out !== 16'sd1 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_1: got %0d/%b want 1/1", out, out_valid); end
        @(negedge clk); idle();
        n_vec++; if (out !== 16'sd4 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_4: got %0d/%b want 4/1", out, out_valid); end
        @(negedge clk);
        n_vec++; if (out !== 16'sd9 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_9: got %0d/%b want 9/1", out, out_valid); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        beat(2'd2, 1, 1, 0, 1'b0);
        @(negedge clk); beat(2'd2, 2, 2, 0, 1'b0);
        @(negedge clk); beat(2'd2, 3, 3, 0, 1'b0);
        n_vec++; if (out !== 16'sd1 || out_valid !== 1'b1) begin n_err++; $display("FAIL stall_1: got %0d/%b want 1/1", out, out_valid); end
        @(negedge clk); idle(); en = 1'b0;
        n_vec++; if (out !== 16'sd4 || out_valid !== 1'b1) begin n_err++; $display("FAIL stall_4: got %0d/%b want 4/1", out, out_valid); end
        @(negedge clk);
        n_vec++; if (out !== 16'sd4 || out_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold1: got %0d/%b want 4/1", out, out_valid); end
        @(negedge clk); en = 1'b1;
        n_vec++; if (out !== 16'sd4 || out_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold2: got %0d/%b want 4/1", out, out_valid); end
        @(negedge clk);
        n_vec++; if (out !== 16'sd9 || out_valid !== 1'b1) begin n_err++; $display("FAIL stall_9: got %0d/%b want 9/1", out, out_valid); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_end: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_run();
        beat(2'd1, 10, 10, 0, 1'b0);
        @(negedge clk); beat(2'd1, 10, 10, 0, 1'b0);
        @(negedge clk); idle(); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        n_vec++; if (out !== 16'sd0 || out_wide !== 20'sd0 || out_valid !== 1'b0 || overflow !== 1'b0)
            begin n_err++; $display("FAIL rst_mid_zero: got out=%0d wide=%0d v=%b o=%b want 0", out, out_wide, out_valid, overflow); end
        beat(2'd1, 1, 1, 0, 1'b1);
        @(negedge clk); idle();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_flush: got %b want 0", out_valid); end
        @(negedge clk);
        n_vec++; if (out !== 16'sd1 || out_valid !== 1'b1) begin n_err++; $display("FAIL rst_mid_out: got %0d/%b want 1/1", out, out_valid); end
        n_vec++; if (out_wide !== 20'sd1) begin n_err++; $display("FAIL rst_mid_wide: got %0d want 1", out_wide); end
        @(negedge clk);
    endtask

    task automatic test_add_and_single_acc();
        beat(2'd3, -128, 77, -128, 1'b0);
        @(negedge clk); beat(2'd1, 5, 5, 0, 1'b1);
        @(negedge clk); idle();
        n_vec++; if (out !== -16'sd256 || out_valid !== 1'b1) begin n_err++; $display("FAIL add_out: got %0d/%b want -256/1", out, out_valid); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL add_ovf: got %b want 0", overflow); end
        @(negedge clk);
        n_vec++; if (out !== 16'sd25 || out_valid !== 1'b1) begin n_err++; $display("FAIL acc1_out: got %0d/%b want 25/1", out, out_valid); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL acc1_ovf: got %b want 0", overflow); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL acc1_end: got %b want 0", out_valid); end
        beat(2'd2, 2, 3, 0, 1'b0);
        @(negedge clk); idle();
        @(negedge clk);
        n_vec++; if (out !== 16'sd6 || out_valid !== 1'b1) begin n_err++; $display("FAIL acc1_idle_after: got %0d/%b want 6/1", out, out_valid); end
    endtask

    initial begin
        test_reset();
        test_mul_add();
        test_acc_pos();
        test_acc_neg();
        test_back_to_back();
        test_stall();
        test_reset_mid_run();
        test_add_and_single_acc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
